// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data memory sequencer.
package mem_stage_ctrl_pkg;

    // Access sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } mem_state_t;

    // ResultSrc encodings of the RV32I datapath
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam int unsigned DEFAULT_MEM_TIMEOUT = 255;
    localparam int unsigned TMO_CNT_W           = 16;
    localparam int unsigned XLEN                = 32;

endpackage : mem_stage_ctrl_pkg

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: one bus transaction per load/store, pipeline freeze
// while it is in flight, sticky fault on misalignment, bus error or timeout.
module mem_stage_ctrl
#(
    parameter int unsigned TIMEOUT_CYCLES = mem_stage_ctrl_pkg::DEFAULT_MEM_TIMEOUT,
    parameter logic [1:0]  RESULT_MEM     = mem_stage_ctrl_pkg::RESULT_MEM
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite_m,
    input  logic [1:0]  ResultSrc_m,
    input  logic [31:0] ALUResult_m,
    input  logic [31:0] WriteData_m,
    input  logic [31:0] pc_m,
    input  logic        ext_stall,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,
    input  logic        resp_err,
    output logic        stall_m,
    output logic        flush_w,
    output logic [31:0] ReadData_m,
    output logic        mem_fault,
    output logic [31:0] fault_pc
);
    import mem_stage_ctrl_pkg::*;

    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

    mem_state_t           r_state;
    logic [TMO_CNT_W-1:0] r_tmo_cnt;
    logic                 r_req_valid;
    logic                 r_req_we;
    logic [XLEN-1:0]      r_req_addr;
    logic [XLEN-1:0]      r_req_wdata;
    logic [XLEN-1:0]      r_read_data;
    logic                 r_mem_fault;
    logic [XLEN-1:0]      r_fault_pc;

    logic                 w_access;
    logic                 w_aligned;
    logic [TMO_CNT_W-1:0] w_cnt_inc;
    logic                 w_timeout;
    logic                 w_stall;

    assign w_access  = MemWrite_m | (ResultSrc_m == RESULT_MEM);
    assign w_aligned = (ALUResult_m[1:0] == 2'b00);
    // Saturating increment so a huge limit can never wrap the counter
    assign w_cnt_inc = (r_tmo_cnt == {TMO_CNT_W{1'b1}}) ? r_tmo_cnt
                                                         : r_tmo_cnt + TMO_CNT_W'(1);
    assign w_timeout = (w_cnt_inc >= TMO_LIMIT);

    // Pipeline freeze / bubble injection decoded from the current state
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE:  w_stall = w_access;
            ST_REQ:   w_stall = 1'b1;
            ST_RESP:  w_stall = 1'b1;
            ST_DONE:  w_stall = 1'b0;
            ST_FAULT: w_stall = 1'b1;
            default:  w_stall = 1'b1;
        endcase
    end

    // Held low during reset so the core sees no stall/flush while rst_n is low
    assign stall_m = rst_n & w_stall;
    assign flush_w = rst_n & w_stall;

    // Access sequencer with registered bus and fault outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tmo_cnt   <= '0;
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_read_data <= '0;
            r_mem_fault <= 1'b0;
            r_fault_pc  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        if (w_aligned) begin
                            r_state     <= ST_REQ;
                            r_tmo_cnt   <= '0;
                            r_req_valid <= 1'b1;
                            r_req_we    <= MemWrite_m;
                            r_req_addr  <= {ALUResult_m[31:2], 2'b00};
                            if (MemWrite_m) begin
                                r_req_wdata <= WriteData_m;
                            end
                        end else begin
                            r_state     <= ST_FAULT;
                            r_mem_fault <= 1'b1;
                            r_fault_pc  <= pc_m;
                        end
                    end
                end
                ST_REQ: begin
                    r_tmo_cnt <= w_cnt_inc;
                    if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= r_req_we ? ST_DONE : ST_RESP;
                    end else if (w_timeout) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_FAULT;
                        r_mem_fault <= 1'b1;
                        r_fault_pc  <= pc_m;
                    end
                end
                ST_RESP: begin
                    r_tmo_cnt <= w_cnt_inc;
                    if (resp_valid) begin
                        if (resp_err) begin
                            r_state     <= ST_FAULT;
                            r_mem_fault <= 1'b1;
                            r_fault_pc  <= pc_m;
                        end else begin
                            r_read_data <= resp_rdata;
                            r_state     <= ST_DONE;
                        end
                    end else if (w_timeout) begin
                        r_state     <= ST_FAULT;
                        r_mem_fault <= 1'b1;
                        r_fault_pc  <= pc_m;
                    end
                end
                ST_DONE: begin
                    // A downstream stall keeps the M register (and us) in place
                    if (!ext_stall) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    r_req_valid <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid  = r_req_valid;
    assign req_we     = r_req_we;
    assign req_addr   = r_req_addr;
    assign req_wdata  = r_req_wdata;
    assign ReadData_m = r_read_data;
    assign mem_fault  = r_mem_fault;
    assign fault_pc   = r_fault_pc;

endmodule : mem_stage_ctrl

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stores, downstream stall,
// timeout, misalignment, bus error and asynchronous reset mid-access.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        MemWrite_m;
    logic [1:0]  ResultSrc_m;
    logic [31:0] ALUResult_m;
    logic [31:0] WriteData_m;
    logic [31:0] pc_m;
    logic        ext_stall;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall_m;
    logic        flush_w;
    logic [31:0] ReadData_m;
    logic        mem_fault;
    logic [31:0] fault_pc;

    int total  = 0;
    int bad    = 0;
    int hs_cnt = 0;
    int rv_cnt = 0;
    int n;
    int h0;

    mem_stage_ctrl #(
        .TIMEOUT_CYCLES (8),
        .RESULT_MEM     (2'b01)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemWrite_m  (MemWrite_m),
        .ResultSrc_m (ResultSrc_m),
        .ALUResult_m (ALUResult_m),
        .WriteData_m (WriteData_m),
        .pc_m        (pc_m),
        .ext_stall   (ext_stall),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .stall_m     (stall_m),
        .flush_w     (flush_w),
        .ReadData_m  (ReadData_m),
        .mem_fault   (mem_fault),
        .fault_pc    (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake and request-valid cycle counters
    always @(posedge clk) begin
        if (req_valid && req_ready) hs_cnt++;
        if (req_valid) rv_cnt++;
    end

    // A response while a request is still outstanding breaks the protocol
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(req_valid && resp_valid)) else begin
                bad++;
                $error("FAIL proto: resp_valid while req_valid observed=1 expected=0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        MemWrite_m  = 1'b0;
        ResultSrc_m = 2'b00;
        ALUResult_m = 32'h0;
        WriteData_m = 32'h0;
        ext_stall   = 1'b0;
    endtask

    task automatic do_reset();
        set_nop();
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        rst_n      = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset with a load sitting in M: everything must stay at 0
        rst_n       = 1'b0;
        set_nop();
        ResultSrc_m = 2'b01;
        ALUResult_m = 32'h10;
        pc_m        = 32'h0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = 32'h0;
        resp_err    = 1'b0;
        cyc();
        cyc();
        chk1 ("rst_req_valid", req_valid, 1'b0);
        chk1 ("rst_stall_m",   stall_m,   1'b0);
        chk1 ("rst_flush_w",   flush_w,   1'b0);
        chk1 ("rst_mem_fault", mem_fault, 1'b0);
        chk32("rst_read_data", ReadData_m, 32'h0);
        chk32("rst_fault_pc",  fault_pc,  32'h0);
        chk32("rst_req_addr",  req_addr,  32'h0);
        set_nop();
        rst_n = 1'b1;
        cyc();
        chk1 ("idle_nop_stall", stall_m, 1'b0);

        // Load 0x10, immediate ready and response
        ResultSrc_m = 2'b01;
        ALUResult_m = 32'h10;
        pc_m        = 32'h40;
        req_ready   = 1'b1;
        n = 0;
        #1;
        if (stall_m) n++;
        chk1 ("t1_idle_flush", flush_w, 1'b1);
        cyc();
        if (stall_m) n++;
        chk1 ("t1_req_valid", req_valid, 1'b1);
        chk32("t1_req_addr",  req_addr,  32'h10);
        chk1 ("t1_req_we",    req_we,    1'b0);
        cyc();
        if (stall_m) n++;
        chk1 ("t1_resp_reqv", req_valid, 1'b0);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = 32'hDEAD_BEEF;
        cyc();
        if (stall_m) n++;
        chk32("t1_done_data",  ReadData_m, 32'hDEAD_BEEF);
        chk1 ("t1_done_flush", flush_w,    1'b0);
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        set_nop();
        cyc();
        if (stall_m) n++;
        chk32("t1_data_hold",  ReadData_m, 32'hDEAD_BEEF);
        chk32("t1_stall_cnt",  32'(n),     32'd3);

        // Store 0x12345678 to 0x20 with ready held low for 5 cycles
        MemWrite_m  = 1'b1;
        ALUResult_m = 32'h20;
        WriteData_m = 32'h1234_5678;
        pc_m        = 32'h48;
        req_ready   = 1'b0;
        h0 = hs_cnt;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk1 ("t2_wait_valid", req_valid, 1'b1);
            chk32("t2_wait_addr",  req_addr,  32'h20);
            chk32("t2_wait_wdata", req_wdata, 32'h1234_5678);
            chk1 ("t2_wait_we",    req_we,    1'b1);
            cyc();
        end
        chk1 ("t2_still_valid", req_valid, 1'b1);
        req_ready = 1'b1;
        cyc();
        chk1 ("t2_done_stall", stall_m,   1'b0);
        chk1 ("t2_done_reqv",  req_valid, 1'b0);
        chk32("t2_hs_count",   32'(hs_cnt - h0), 32'd1);
        set_nop();
        req_ready = 1'b0;
        cyc();

        // Load then store, downstream stall holds the load's DONE 3 cycles
        ResultSrc_m = 2'b01;
        ALUResult_m = 32'h30;
        pc_m        = 32'h4C;
        req_ready   = 1'b1;
        cyc();
        cyc();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = 32'hCAFE_F00D;
        cyc();
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        ext_stall  = 1'b1;
        chk32("t3_done1_data",  ReadData_m, 32'hCAFE_F00D);
        chk1 ("t3_done1_stall", stall_m,    1'b0);
        cyc();
        chk1 ("t3_done2_stall", stall_m,    1'b0);
        chk32("t3_done2_data",  ReadData_m, 32'hCAFE_F00D);
        cyc();
        chk1 ("t3_done3_stall", stall_m,    1'b0);
        chk32("t3_done3_data",  ReadData_m, 32'hCAFE_F00D);
        ext_stall = 1'b0;
        cyc();
        MemWrite_m  = 1'b1;
        ResultSrc_m = 2'b00;
        ALUResult_m = 32'h40;
        WriteData_m = 32'hA5A5_0F0F;
        pc_m        = 32'h50;
        req_ready   = 1'b1;
        h0 = hs_cnt;
        #1;
        chk1 ("t3_idle_stall", stall_m,   1'b1);
        chk1 ("t3_idle_reqv",  req_valid, 1'b0);
        cyc();
        chk1 ("t3_st_valid", req_valid, 1'b1);
        chk1 ("t3_st_we",    req_we,    1'b1);
        chk32("t3_st_addr",  req_addr,  32'h40);
        chk32("t3_st_wdata", req_wdata, 32'hA5A5_0F0F);
        cyc();
        chk32("t3_st_hs",    32'(hs_cnt - h0), 32'd1);
        chk32("t3_st_rdata", ReadData_m, 32'hCAFE_F00D);
        set_nop();
        req_ready = 1'b0;
        cyc();

        // Asynchronous reset while waiting for a load response
        ResultSrc_m = 2'b01;
        ALUResult_m = 32'h60;
        pc_m        = 32'h54;
        req_ready   = 1'b1;
        cyc();
        cyc();
        req_ready = 1'b0;
        chk1 ("t4_resp_stall", stall_m, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1 ("t4_arst_reqv",  req_valid,  1'b0);
        chk32("t4_arst_addr",  req_addr,   32'h0);
        chk1 ("t4_arst_stall", stall_m,    1'b0);
        chk32("t4_arst_data",  ReadData_m, 32'h0);
        set_nop();
        resp_valid = 1'b1;
        resp_rdata = 32'hBAD0_BAD0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk32("t4_late_data",  ReadData_m, 32'h0);
        chk1 ("t4_late_stall", stall_m,    1'b0);
        chk1 ("t4_late_reqv",  req_valid,  1'b0);
        resp_valid  = 1'b0;
        resp_rdata  = 32'h0;
        ResultSrc_m = 2'b01;
        ALUResult_m = 32'h70;
        pc_m        = 32'h58;
        req_ready   = 1'b1;
        cyc();
        chk32("t4_new_addr", req_addr, 32'h70);
        cyc();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = 32'h0BAD_F00D;
        cyc();
        chk32("t4_new_data",  ReadData_m, 32'h0BAD_F00D);
        chk1 ("t4_new_stall", stall_m,    1'b0);
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        set_nop();
        cyc();

        // Load with no response: fault after 8 waiting cycles
        ResultSrc_m = 2'b01;
        ALUResult_m = 32'h80;
        pc_m        = 32'h44;
        req_ready   = 1'b1;
        cyc();
        n = 1;
        cyc();
        req_ready = 1'b0;
        while (!mem_fault && n < 20) begin
            n++;
            cyc();
        end
        chk32("t5_wait_cycles", 32'(n),   32'd8);
        chk1 ("t5_fault",       mem_fault, 1'b1);
        chk32("t5_fault_pc",    fault_pc,  32'h44);
        chk1 ("t5_reqv",        req_valid, 1'b0);
        chk1 ("t5_stall",       stall_m,   1'b1);
        chk1 ("t5_flush",       flush_w,   1'b1);
        set_nop();
        pc_m = 32'h99C;
        cyc();
        chk32("t5_pc_sticky",    fault_pc,  32'h44);
        chk1 ("t5_fault_sticky", mem_fault, 1'b1);
        chk1 ("t5_stall_sticky", stall_m,   1'b1);

        // Misaligned load: fault with no request
        do_reset();
        chk1 ("t6_rst_fault", mem_fault, 1'b0);
        h0 = rv_cnt;
        ResultSrc_m = 2'b01;
        ALUResult_m = 32'h3;
        pc_m        = 32'h58;
        cyc();
        chk1 ("t6_fault",    mem_fault, 1'b1);
        chk32("t6_fault_pc", fault_pc,  32'h58);
        chk1 ("t6_reqv",     req_valid, 1'b0);
        chk1 ("t6_stall",    stall_m,   1'b1);
        cyc();
        chk32("t6_no_req",   32'(rv_cnt - h0), 32'd0);

        // Bus error on a load response
        do_reset();
        ResultSrc_m = 2'b01;
        ALUResult_m = 32'h90;
        pc_m        = 32'h5C;
        req_ready   = 1'b1;
        cyc();
        cyc();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        resp_rdata = 32'hFFFF_FFFF;
        cyc();
        chk1 ("t7_fault",    mem_fault,  1'b1);
        chk32("t7_fault_pc", fault_pc,   32'h5C);
        chk32("t7_no_data",  ReadData_m, 32'h0);
        chk1 ("t7_stall",    stall_m,    1'b1);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_stage_ctrl

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the MEM stage of the pipelined RV32I core against a data memory with a valid/ready request channel and a separate response channel.
- Detects load/store instructions held in the EX/MEM register and issues exactly one bus transaction per instruction.
- Freezes the upstream pipeline registers and injects bubbles into MEM/WB until the access completes, then returns load data.
- Detects misalignment and timeouts and halts the core with a sticky fault.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+RESP before a fault; legal range 1..65535.
- RESULT_MEM, 2'b01: ResultSrc encoding that marks a load.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- MemWrite_m  in  1  MEM-stage store
- ResultSrc_m  in  2  MEM-stage result select; equal to RESULT_MEM means load
- ALUResult_m  in  32  byte address
- WriteData_m  in  32  store data
- pc_m  in  32  MEM-stage PC, used for fault reporting
- ext_stall  in  1  stall from hazard unit or a later stage
- req_valid  out  1  bus request valid
- req_ready  in  1  bus request accept
- req_we  out  1  1 = write
- req_addr  out  32  word-aligned address
- req_wdata  out  32  write data
- resp_valid  in  1  read response valid
- resp_rdata  in  32  read data
- resp_err  in  1  response error, qualified by resp_valid
- stall_m  out  1  drives enable low on F/D, D/E and E/M registers
- flush_w  out  1  drives clear on the M/W register
- ReadData_m  out  32  load data, valid in DONE
- mem_fault  out  1  sticky fault
- fault_pc  out  32  pc_m of the faulting instruction

Behaviour:
- access = MemWrite_m | (ResultSrc_m == RESULT_MEM). A flushed E/M entry has MemWrite=0 and ResultSrc=00, so it generates no access.
- States: IDLE, REQ, RESP, DONE, FAULT.
- Async reset forces IDLE, timeout counter to 0 and every output to 0. req_valid drops immediately, including mid-transaction. A late resp_valid after reset is ignored.
- stall_m and flush_w are combinational from state and inputs.
  - IDLE: both equal access.
  - REQ and RESP: both 1.
  - DONE: both 0.
  - FAULT: stall_m=1, flush_w=1.
- IDLE:
  - access with ALUResult_m[1:0]==0: latch req_addr, req_wdata (stores only) and req_we=MemWrite_m; go to REQ.
  - access with ALUResult_m[1:0]!=0: go to FAULT with no bus request.
  - No access: stay in IDLE.
- REQ:
  - req_valid=1; address and data are held stable until accepted.
  - On req_ready: a store goes to DONE, a load goes to RESP.
  - req_valid deasserts in the cycle after acceptance.
- RESP:
  - On resp_valid with resp_err=0: capture resp_rdata into ReadData_m; go to DONE.
  - On resp_valid with resp_err=1: go to FAULT.
  - resp_valid arriving while in REQ is a protocol violation; the bench flags it as an assertion error.
- DONE:
  - Pipeline is released for one cycle; ReadData_m is held.
  - If ext_stall=1, stay in DONE; the M register does not advance.
  - Otherwise go to IDLE. The next cycle sees the new MEM-stage instruction, so back-to-back accesses are never merged.
- Timeout counter:
  - Cleared on IDLE->REQ; increments in REQ and RESP.
  - When it reaches TIMEOUT_CYCLES while still waiting, go to FAULT (a handshake in the same cycle takes priority).
  - Counter width is 16 bits and saturates, so it never wraps.
- FAULT:
  - Entered from any path: latch fault_pc=pc_m and set mem_fault=1.
  - req_valid=0; the core stays frozen. Only rst_n exits.
- ReadData_m keeps its last load value outside DONE and is updated only by a successful load.
- Minimum in-M latency:
  - Load with ready and response both immediate: 4 cycles (IDLE, REQ, RESP, DONE), 3 of them stalled.
  - Store: 3 cycles (IDLE, REQ, DONE).

Decomposition:
- Shared package holds:
  - mem_state_t enum (IDLE, REQ, RESP, DONE, FAULT).
  - RESULT_MEM and the other ResultSrc encodings (ALU=00, MEM=01, PC4=10).
  - DEFAULT_MEM_TIMEOUT.
- Single module; the timeout counter stays inline. No sub-module is warranted.

Test Plan:
- Load at addr 0x0000_0010; req_ready=1 in REQ; resp_valid next cycle with rdata 0xDEAD_BEEF -> req_addr=0x10, req_we=0; stall_m high for exactly 3 cycles; ReadData_m=0xDEADBEEF in DONE.
- Store 0x1234_5678 to 0x20; req_ready held low for 5 cycles -> req_valid, req_addr and req_wdata stable all 5 cycles; one handshake; DONE after it; stall_m low in DONE.
- Back-to-back load then store; ext_stall=1 for 2 cycles during the load's DONE -> DONE held 3 cycles, ReadData_m stable; then the store is issued as a separate transaction.
- Load with TIMEOUT_CYCLES=8 and no response -> FAULT after 8 waiting cycles; mem_fault=1; fault_pc equals pc_m (e.g. 0x0000_0044); req_valid=0; stall stays high.
- Misaligned load at 0x0000_0003 -> FAULT next cycle with no req_valid pulse; mem_fault=1. resp_err=1 on a valid load -> FAULT with fault_pc latched.
- rst_n asserted mid-RESP -> outputs 0 asynchronously. After release: IDLE, late resp_valid ignored, and a fresh load completes normally.
